// File: rtl/axis_fifo_ctrl_pkg.sv
// Shared FIFO command codes, host op encodings and controller states.
// The FIFO and its controller both decode commands from this package.
package axis_fifo_ctrl_pkg;

    localparam int CmdCodeWidth = 4;

    typedef enum logic [3:0] {
        CMD_SET_EN     = 4'd0,
        CMD_SET_WR_POS = 4'd1,
        CMD_SET_RD_POS = 4'd2,
        CMD_SET_FULL   = 4'd3,
        CMD_SET_LENGTH = 4'd4,
        CMD_GET_EN     = 4'd5,
        CMD_GET_WR_POS = 4'd6,
        CMD_GET_RD_POS = 4'd7,
        CMD_GET_FULL   = 4'd8,
        CMD_GET_LENGTH = 4'd9
    } cmd_code_e;

    typedef enum logic [1:0] {
        OP_FLUSH  = 2'd0,
        OP_QUERY  = 2'd1,
        OP_SET_EN = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_ST = 2'd2,
        S_RESP    = 2'd3
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Get commands return one status beat; Set commands return nothing.
    function automatic logic cmd_is_get(input cmd_code_e c);
        return c >= CMD_GET_EN;
    endfunction

endpackage

// File: rtl/axis_fifo_ctrl_level.sv
// FIFO occupancy from write/read positions, full flag and length-1.
// Pure combinational; result is PosWidth+1 bits so a full FIFO fits.
module fifo_level_calc #(
    parameter int PosWidth = 3
) (
    input  logic [PosWidth-1:0] wr_pos,
    input  logic [PosWidth-1:0] rd_pos,
    input  logic [PosWidth-1:0] len_m1,
    input  logic                full,
    output logic [PosWidth:0]   level
);

    logic [PosWidth:0] len;
    logic [PosWidth:0] wr_ext;
    logic [PosWidth:0] rd_ext;

    always_comb begin
        len    = {1'b0, len_m1} + {{PosWidth{1'b0}}, 1'b1};
        wr_ext = {1'b0, wr_pos};
        rd_ext = {1'b0, rd_pos};
        if (full) begin
            level = len;
        end else if (wr_pos >= rd_pos) begin
            level = wr_ext - rd_ext;
        end else begin
            level = wr_ext + len - rd_ext;
        end
    end

endmodule

// File: rtl/axis_fifo_ctrl.sv
// Host-side controller that turns FLUSH/QUERY/SET_EN requests into
// FIFO command/status stream sequences, one operation at a time.
module axis_fifo_ctrl
    import axis_fifo_ctrl_pkg::*;
#(
    parameter int PosWidth      = 3,
    parameter int TimeoutCycles = 16,
    localparam int CmdDataWidth = max_int(PosWidth, 2)
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [1:0]                          req_op,
    input  logic [1:0]                          req_arg,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [PosWidth:0]                   rsp_level,
    output logic                                rsp_full,
    output logic                                rsp_error,
    output logic                                cmd_tvalid,
    input  logic                                cmd_tready,
    output logic [CmdDataWidth+CmdCodeWidth-1:0] cmd_tdata,
    input  logic                                status_tvalid,
    output logic                                status_tready,
    input  logic [CmdDataWidth-1:0]             status_tdata
);

    localparam int TmoWidth = $clog2(TimeoutCycles + 1);
    localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TimeoutCycles - 1);

    typedef struct packed {
        logic [CmdDataWidth-1:0] arg;
        cmd_code_e               code;
    } cmd_t;

    state_e                        state_q, state_d;
    op_e                           op_q, op_d;
    logic [1:0]                    arg_q, arg_d;
    logic [2:0]                    step_q, step_d;
    logic [TmoWidth-1:0]           tmo_q, tmo_d;
    logic [3:0][CmdDataWidth-1:0]  st_q, st_d;
    logic                          cmd_tvalid_q, cmd_tvalid_d;
    cmd_t                          cmd_tdata_q, cmd_tdata_d;
    logic                          status_tready_q, status_tready_d;
    logic                          rsp_valid_q, rsp_valid_d;
    logic [PosWidth:0]             rsp_level_q, rsp_level_d;
    logic                          rsp_full_q, rsp_full_d;
    logic                          rsp_error_q, rsp_error_d;
    logic [PosWidth:0]             level;
    cmd_t                          nxt_cmd;

    function automatic cmd_t seq_cmd(
        input op_e                     op,
        input logic [2:0]              step,
        input logic [1:0]              en_arg,
        input logic [CmdDataWidth-1:0] saved
    );
        cmd_t c;
        c.code = CMD_SET_EN;
        c.arg  = '0;
        case (op)
            OP_FLUSH: begin
                case (step)
                    3'd0:    c.code = CMD_GET_EN;
                    3'd1:    c.code = CMD_SET_EN;
                    3'd2:    c.code = CMD_SET_WR_POS;
                    3'd3:    c.code = CMD_SET_RD_POS;
                    3'd4:    c.code = CMD_SET_FULL;
                    default: c.arg  = saved;
                endcase
            end
            OP_QUERY: begin
                case (step)
                    3'd0:    c.code = CMD_GET_WR_POS;
                    3'd1:    c.code = CMD_GET_RD_POS;
                    3'd2:    c.code = CMD_GET_FULL;
                    default: c.code = CMD_GET_LENGTH;
                endcase
            end
            default: c.arg = CmdDataWidth'(en_arg);
        endcase
        return c;
    endfunction

    function automatic logic [2:0] last_step(input op_e op);
        case (op)
            OP_FLUSH: return 3'd5;
            OP_QUERY: return 3'd3;
            default:  return 3'd0;
        endcase
    endfunction

    // Status beats land in the slot of the step that requested them.
    always_comb begin
        st_d = st_q;
        if (state_q == S_WAIT_ST && status_tvalid) begin
            st_d[step_q[1:0]] = status_tdata;
        end
    end

    fifo_level_calc #(
        .PosWidth (PosWidth)
    ) u_level (
        .wr_pos (st_d[0][PosWidth-1:0]),
        .rd_pos (st_d[1][PosWidth-1:0]),
        .len_m1 (st_d[3][PosWidth-1:0]),
        .full   (st_d[2] != '0),
        .level  (level)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        arg_d       = arg_q;
        step_d      = step_q;
        tmo_d       = tmo_q;
        rsp_level_d = rsp_level_q;
        rsp_full_d  = rsp_full_q;
        rsp_error_d = rsp_error_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d        = op_e'(req_op);
                    arg_d       = req_arg;
                    step_d      = '0;
                    tmo_d       = '0;
                    rsp_level_d = '0;
                    rsp_full_d  = 1'b0;
                    rsp_error_d = 1'b0;
                    if (op_e'(req_op) == OP_RSVD) begin
                        state_d     = S_RESP;
                        rsp_error_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (cmd_tready) begin
                    if (cmd_is_get(cmd_tdata_q.code)) begin
                        state_d = S_WAIT_ST;
                        tmo_d   = '0;
                    end else if (step_q == last_step(op_q)) begin
                        state_d = S_RESP;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            S_WAIT_ST: begin
                if (status_tvalid) begin
                    tmo_d = '0;
                    if (step_q == last_step(op_q)) begin
                        state_d = S_RESP;
                        if (op_q == OP_QUERY) begin
                            rsp_level_d = level;
                            rsp_full_d  = st_d[2] != '0;
                        end
                    end else begin
                        state_d = S_ISSUE;
                        step_d  = step_q + 3'd1;
                    end
                end else if (tmo_q == TmoLast) begin
                    state_d     = S_RESP;
                    rsp_error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_level_d = '0;
                    rsp_full_d  = 1'b0;
                    rsp_error_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        nxt_cmd         = seq_cmd(op_d, step_d, arg_d, st_d[0]);
        cmd_tvalid_d    = state_d == S_ISSUE;
        cmd_tdata_d     = cmd_tvalid_d ? nxt_cmd : '0;
        status_tready_d = state_d == S_WAIT_ST;
        rsp_valid_d     = state_d == S_RESP;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q         <= S_IDLE;
            op_q            <= OP_FLUSH;
            arg_q           <= '0;
            step_q          <= '0;
            tmo_q           <= '0;
            st_q            <= '0;
            cmd_tvalid_q    <= 1'b0;
            cmd_tdata_q     <= '0;
            status_tready_q <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_level_q     <= '0;
            rsp_full_q      <= 1'b0;
            rsp_error_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            arg_q           <= arg_d;
            step_q          <= step_d;
            tmo_q           <= tmo_d;
            st_q            <= st_d;
            cmd_tvalid_q    <= cmd_tvalid_d;
            cmd_tdata_q     <= cmd_tdata_d;
            status_tready_q <= status_tready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_level_q     <= rsp_level_d;
            rsp_full_q      <= rsp_full_d;
            rsp_error_q     <= rsp_error_d;
        end
    end

    assign req_ready     = state_q == S_IDLE;
    assign cmd_tvalid    = cmd_tvalid_q;
    assign cmd_tdata     = cmd_tdata_q;
    assign status_tready = status_tready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_level     = rsp_level_q;
    assign rsp_full      = rsp_full_q;
    assign rsp_error     = rsp_error_q;

endmodule

// File: tb/tb_axis_fifo_ctrl.sv
// Bench for axis_fifo_ctrl: behavioural 8-deep FIFO command responder,
// scoreboard queues for expected commands and expected responses.
module tb_axis_fifo_ctrl;
    import axis_fifo_ctrl_pkg::*;

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'd0;
    logic [1:0] req_arg = 2'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_level;
    logic       rsp_full;
    logic       rsp_error;
    logic       cmd_tvalid;
    logic       cmd_tready = 1'b0;
    logic [6:0] cmd_tdata;
    logic       status_tvalid = 1'b0;
    logic       status_tready;
    logic [2:0] status_tdata = 3'd0;

    axis_fifo_ctrl #(
        .PosWidth      (3),
        .TimeoutCycles (16)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_arg       (req_arg),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_level     (rsp_level),
        .rsp_full      (rsp_full),
        .rsp_error     (rsp_error),
        .cmd_tvalid    (cmd_tvalid),
        .cmd_tready    (cmd_tready),
        .cmd_tdata     (cmd_tdata),
        .status_tvalid (status_tvalid),
        .status_tready (status_tready),
        .status_tdata  (status_tdata)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [1:0] m_en = 2'd0;
    logic [2:0] m_wr = 3'd0;
    logic [2:0] m_rd = 3'd0;
    logic       m_full = 1'b0;
    localparam logic [2:0] MLen1 = 3'd7;

    logic [6:0] exp_cmd[$];
    logic [5:0] exp_rsp[$];
    logic [2:0] stq[$];

    int         stall_cnt = 0;
    bit         mute = 1'b0;
    int         hold_code = -1;
    bit         stalled = 1'b0;
    logic [6:0] held = '0;
    bit         got_rsp = 1'b0;
    int         fire_cyc = 0;
    int         rsp_cyc = 0;

    function automatic void push_cmd(input int code, input int arg);
        logic [2:0] a;
        logic [3:0] c;
        a = arg[2:0];
        c = code[3:0];
        exp_cmd.push_back({a, c});
    endfunction

    function automatic void push_rsp(input int lvl, input bit full, input bit err);
        logic [3:0] l;
        l = lvl[3:0];
        exp_rsp.push_back({l, full, err});
    endfunction

    // One negedge worth of FIFO-side and response-side behaviour.
    task automatic service();
        logic [6:0] e;
        logic [5:0] r;
        logic [3:0] code;
        logic [2:0] a;
        if (stalled) begin
            checks++;
            if ({cmd_tvalid, cmd_tdata} !== {1'b1, held}) begin
                errors++;
                $display("FAIL cmd_stable got %0b/%h want 1/%h", cmd_tvalid, cmd_tdata, held);
            end
        end
        cmd_tready = 1'b1;
        if (cmd_tvalid && stall_cnt > 0) begin
            cmd_tready = 1'b0;
            stall_cnt--;
        end
        if (cmd_tvalid && hold_code >= 0 && int'(cmd_tdata[3:0]) == hold_code) cmd_tready = 1'b0;
        stalled = cmd_tvalid && !cmd_tready;
        held = cmd_tdata;
        if (cmd_tvalid && cmd_tready) begin
            fire_cyc = cyc;
            checks++;
            if (exp_cmd.size() == 0) begin
                errors++;
                $display("FAIL cmd_extra got %h want none", cmd_tdata);
            end else begin
                e = exp_cmd.pop_front();
                if (cmd_tdata !== e) begin
                    errors++;
                    $display("FAIL cmd_seq got %h want %h", cmd_tdata, e);
                end
            end
            code = cmd_tdata[3:0];
            a = cmd_tdata[6:4];
            case (code)
                4'd0: m_en = a[1:0];
                4'd1: m_wr = a;
                4'd2: m_rd = a;
                4'd3: m_full = a[0];
                4'd5: stq.push_back({1'b0, m_en});
                4'd6: stq.push_back(m_wr);
                4'd7: stq.push_back(m_rd);
                4'd8: stq.push_back({2'b00, m_full});
                4'd9: stq.push_back(MLen1);
                default: ;
            endcase
        end
        status_tvalid = (stq.size() > 0) && !mute;
        status_tdata = (stq.size() > 0) ? stq[0] : 3'd0;
        if (status_tvalid && status_tready) void'(stq.pop_front());
        rsp_ready = 1'b1;
        if (rsp_valid) begin
            got_rsp = 1'b1;
            rsp_cyc = cyc;
            checks++;
            if (exp_rsp.size() == 0) begin
                errors++;
                $display("FAIL rsp_extra got %h want none", {rsp_level, rsp_full, rsp_error});
            end else begin
                r = exp_rsp.pop_front();
                if ({rsp_level, rsp_full, rsp_error} !== r) begin
                    errors++;
                    $display("FAIL rsp got lvl=%0d full=%0b err=%0b want lvl=%0d full=%0b err=%0b",
                             rsp_level, rsp_full, rsp_error, r[5:2], r[1], r[0]);
                end
            end
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [1:0] arg, input string name);
        int n;
        bit acc;
        n = 0;
        got_rsp = 1'b0;
        @(negedge aclk);
        req_op = op;
        req_arg = arg;
        req_valid = 1'b1;
        service();
        while (n < 200 && !got_rsp) begin
            acc = req_valid && req_ready;
            @(negedge aclk);
            n++;
            if (acc) req_valid = 1'b0;
            service();
        end
        req_valid = 1'b0;
        checks++;
        if (!got_rsp) begin
            errors++;
            $display("FAIL %s_rsp_timeout got none want rsp", name);
        end
        checks++;
        if (exp_cmd.size() != 0 || exp_rsp.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover got cmd=%0d rsp=%0d want 0/0", name, exp_cmd.size(), exp_rsp.size());
            exp_cmd.delete();
            exp_rsp.delete();
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        checks++;
        if ({cmd_tvalid, status_tready, rsp_valid, rsp_full, rsp_error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {cmd_tvalid, status_tready, rsp_valid, rsp_full, rsp_error});
        end
        checks++;
        if (cmd_tdata !== 7'd0) begin
            errors++;
            $display("FAIL reset_tdata got %h want 0", cmd_tdata);
        end
        checks++;
        if (rsp_level !== 4'd0) begin
            errors++;
            $display("FAIL reset_level got %0d want 0", rsp_level);
        end
        areset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_query();
        m_en = 2'd3; m_wr = 3'd5; m_rd = 3'd0; m_full = 1'b0;
        push_cmd(6, 0); push_cmd(7, 0); push_cmd(8, 0); push_cmd(9, 0);
        push_rsp(5, 1'b0, 1'b0);
        do_op(OP_QUERY, 2'd0, "query5");
        m_wr = 3'd2; m_rd = 3'd6;
        push_cmd(6, 0); push_cmd(7, 0); push_cmd(8, 0); push_cmd(9, 0);
        push_rsp(4, 1'b0, 1'b0);
        do_op(OP_QUERY, 2'd0, "query_wrap");
        m_wr = 3'd3; m_rd = 3'd3; m_full = 1'b1;
        push_cmd(6, 0); push_cmd(7, 0); push_cmd(8, 0); push_cmd(9, 0);
        push_rsp(8, 1'b1, 1'b0);
        do_op(OP_QUERY, 2'd0, "query_full");
    endtask

    task automatic test_flush();
        m_en = 2'd3; m_wr = 3'd6; m_rd = 3'd0; m_full = 1'b0;
        push_cmd(5, 0); push_cmd(0, 0); push_cmd(1, 0);
        push_cmd(2, 0); push_cmd(3, 0); push_cmd(0, 3);
        push_rsp(0, 1'b0, 1'b0);
        do_op(OP_FLUSH, 2'd0, "flush");
        checks++;
        if ({m_en, m_wr, m_rd, m_full} !== {2'd3, 3'd0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL flush_fifo_state got en=%0d wr=%0d rd=%0d full=%0b want 3/0/0/0",
                     m_en, m_wr, m_rd, m_full);
        end
        push_cmd(6, 0); push_cmd(7, 0); push_cmd(8, 0); push_cmd(9, 0);
        push_rsp(0, 1'b0, 1'b0);
        do_op(OP_QUERY, 2'd0, "query_after_flush");
    endtask

    task automatic test_set_en();
        push_cmd(0, 2);
        push_rsp(0, 1'b0, 1'b0);
        do_op(OP_SET_EN, 2'd2, "set_en2");
        checks++;
        if (m_en !== 2'd2) begin
            errors++;
            $display("FAIL set_en_value got %0d want 2", m_en);
        end
        push_cmd(0, 3);
        push_rsp(0, 1'b0, 1'b0);
        do_op(OP_SET_EN, 2'd3, "set_en3");
    endtask

    task automatic test_back_to_back_stall();
        m_wr = 3'd4; m_rd = 3'd1; m_full = 1'b0;
        stall_cnt = 4;
        push_cmd(6, 0); push_cmd(7, 0); push_cmd(8, 0); push_cmd(9, 0);
        push_rsp(3, 1'b0, 1'b0);
        do_op(OP_QUERY, 2'd0, "query_stall");
        checks++;
        if (stall_cnt != 0) begin
            errors++;
            $display("FAIL stall_used got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_timeout();
        int d;
        mute = 1'b1;
        push_cmd(6, 0);
        push_rsp(0, 1'b0, 1'b1);
        do_op(OP_QUERY, 2'd0, "query_timeout");
        d = rsp_cyc - fire_cyc;
        checks++;
        if (d < 16 || d > 18) begin
            errors++;
            $display("FAIL timeout_latency got %0d want 16..18", d);
        end
        stq.delete();
        m_en = 2'd3;
        push_cmd(5, 0);
        push_rsp(0, 1'b0, 1'b1);
        do_op(OP_FLUSH, 2'd0, "flush_timeout");
        checks++;
        if (m_en !== 2'd3) begin
            errors++;
            $display("FAIL flush_timeout_en got %0d want 3", m_en);
        end
        stq.delete();
        mute = 1'b0;
    endtask

    task automatic test_reserved();
        push_rsp(0, 1'b0, 1'b1);
        do_op(OP_RSVD, 2'd0, "reserved");
    endtask

    task automatic test_reset_mid_flush();
        int n;
        bit acc;
        bit seen;
        bit quiet;
        m_en = 2'd3; m_wr = 3'd5; m_rd = 3'd1; m_full = 1'b0;
        hold_code = 2;
        push_cmd(5, 0); push_cmd(0, 0); push_cmd(1, 0);
        @(negedge aclk);
        req_op = OP_FLUSH;
        req_valid = 1'b1;
        service();
        n = 0;
        seen = 1'b0;
        while (n < 60 && !seen) begin
            acc = req_valid && req_ready;
            @(negedge aclk);
            n++;
            if (acc) req_valid = 1'b0;
            service();
            if (cmd_tvalid && cmd_tdata[3:0] == 4'd2) seen = 1'b1;
        end
        req_valid = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midreset_reach got none want cmd 2");
        end
        areset = 1'b1;
        #1;
        checks++;
        if ({cmd_tvalid, status_tready, rsp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_outputs got %b want 000", {cmd_tvalid, status_tready, rsp_valid});
        end
        @(negedge aclk);
        areset = 1'b0;
        hold_code = -1;
        stalled = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_req_ready got %b want 1", req_ready);
        end
        checks++;
        if (exp_cmd.size() != 0) begin
            errors++;
            $display("FAIL midreset_cmds got %0d left want 0", exp_cmd.size());
            exp_cmd.delete();
        end
        quiet = 1'b1;
        repeat (6) begin
            @(negedge aclk);
            if (cmd_tvalid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL midreset_quiet got cmd_tvalid want 0");
        end
        stq.delete();
        m_wr = 3'd3; m_rd = 3'd1;
        push_cmd(6, 0); push_cmd(7, 0); push_cmd(8, 0); push_cmd(9, 0);
        push_rsp(2, 1'b0, 1'b0);
        do_op(OP_QUERY, 2'd0, "query_after_reset");
    endtask

    initial begin
        test_reset();
        test_query();
        test_flush();
        test_set_en();
        test_back_to_back_stall();
        test_timeout();
        test_reserved();
        test_reset_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_fifo_ctrl.md
AXIS_FIFO_CTRL -- requirements
Module: axis_fifo_ctrl

Interface
REQ-001 SHALL have parameter PosWidth, default 3: FIFO position pointer width.
REQ-002 SHALL have parameter TimeoutCycles, default 16: maximum cycles to wait for one status beat.
REQ-003 SHALL use local constant CmdDataWidth = max(PosWidth,2) and command-code width 4.
REQ-004 aclk  in  1  single clock; all logic on rising edge.
REQ-005 areset  in  1  reset, asynchronous, active-high.
REQ-006 req_valid / req_ready  in / out  1 / 1  host operation handshake.
REQ-007 req_op  in  2  operation: 0 FLUSH, 1 QUERY, 2 SET_EN, 3 reserved.
REQ-008 req_arg  in  2  SET_EN value: bit0 input enable, bit1 output enable.
REQ-009 rsp_valid / rsp_ready  out / in  1 / 1  result handshake.
REQ-010 rsp_level  out  PosWidth+1  FIFO occupancy (QUERY only; otherwise 0).
REQ-011 rsp_full, rsp_error  out  1 each  full flag (QUERY), status timeout.
REQ-012 cmd_tvalid / cmd_tready  out / in  1 / 1  FIFO command stream.
REQ-013 cmd_tdata  out  CmdDataWidth+4  bits[3:0] command code, upper bits argument.
REQ-014 status_tvalid / status_tready  in / out  1 / 1  FIFO status stream.
REQ-015 status_tdata  in  CmdDataWidth  status value.

Function
REQ-016 SHALL use states IDLE, ISSUE, WAIT_ST, RESP and a 3-bit step index into the per-op command list.
REQ-017 IDLE: req_ready=1. On req_valid, SHALL latch op and arg, set step=0, clear the error flag, and enter ISSUE. Reserved op SHALL go directly to RESP with rsp_error=1.
REQ-018 ISSUE: SHALL hold cmd_tvalid=1 with cmd_tdata stable until cmd_tready. On the accept cycle, a Get command SHALL go to WAIT_ST; a Set command SHALL advance step, or go to RESP after the last step.
REQ-019 WAIT_ST: status_tready=1. The beat SHALL be stored into the register for the current step. The FSM SHALL then advance step, or go to RESP after the last step.
REQ-020 WAIT_ST timeout: if no beat arrives within TimeoutCycles cycles, SHALL set rsp_error=1 and go to RESP, aborting the remaining steps.
REQ-021 FLUSH sequence:
- GetEnableInputOutput (5): save result.
- SetEnableInputOutput (0), arg 0.
- SetWrPos (1), arg 0.
- SetRdPos (2), arg 0.
- SetFullFlag (3), arg 0.
- SetEnableInputOutput, arg = saved enables.
REQ-022 QUERY sequence: GetWrPos (6), GetRdPos (7), GetFullFlag (8), GetLength (9).
REQ-023 SET_EN sequence: one SetEnableInputOutput command with arg = req_arg.
REQ-024 QUERY level, with len = length_1+1 computed at PosWidth+1 bits:
- full=1: level = len.
- wr>=rd: level = wr-rd.
- otherwise: level = wr+len-rd.
REQ-025 RESP: rsp_valid SHALL stay 1 with outputs stable until rsp_ready, then return to IDLE. Only one operation SHALL be in flight; req_ready=0 outside IDLE.
REQ-026 cmd_tvalid SHALL be 0 in every state except ISSUE. status_tready SHALL be 0 outside WAIT_ST. A status beat arriving outside WAIT_ST SHALL be left unconsumed.
REQ-027 After a timeout on a FLUSH Get, the FIFO enables SHALL be left untouched, because no Set command has yet been issued.

Reset
REQ-028 On areset, state=IDLE, step=0, and the timeout counter=0.
REQ-029 On areset, these outputs SHALL be 0: cmd_tvalid, cmd_tdata, status_tready, rsp_valid, rsp_level, rsp_full, rsp_error.
REQ-030 Reset asserted mid-operation SHALL abandon the sequence without issuing further commands.
REQ-031 req_ready SHALL be 1 in the first cycle after areset deasserts.

Structure
REQ-032 A shared package SHALL hold the 4-bit command codes 0..9, the op encodings, and the state enum. The FIFO and this block SHALL use the same codes.
REQ-033 The level computation SHALL be a separate combinational sub-module, fifo_level_calc.

Verification
REQ-034 QUERY against an 8-deep FIFO holding 5 words (wr=5, rd=0) -> commands 6,7,8,9 in order; rsp_level=5, rsp_full=0, rsp_error=0.
REQ-035 QUERY with wr=2, rd=6, full=0 -> rsp_level=4. QUERY with wr=rd=3, full=1 -> rsp_level=8, rsp_full=1.
REQ-036 FLUSH with enables=2'b11 and 6 words held -> commands 5,0(0),1(0),2(0),3(0),0(3); a subsequent QUERY returns level 0.
REQ-037 cmd_tready held low for 4 cycles during ISSUE -> cmd_tdata stable throughout, and no step is skipped.
REQ-038 status_tvalid never asserted on QUERY -> after 16 cycles rsp_valid=1 with rsp_error=1; no further commands issued.
REQ-039 areset pulsed during FLUSH step 3 -> cmd_tvalid=0 immediately; req_ready=1 after release.
